alu_input_sequencer: RTL and testbench
======================================

ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Parameter DB_CYCLES, default 50000, SHALL set the debounce stability window in clk cycles; it is used only with DEBOUNCE_EN.
REQ-003 Ports SHALL be:
  clk  in  1  system clock, rising edge
  rst_n  in  1  async active-low reset
  sw  in  4  data switches (operand or opcode source)
  btn_next  in  1  raw "advance" button, asynchronous, active-high
  btn_clr  in  1  raw "clear" button, asynchronous, active-high
  alu_result  in  4  combinational result returned by the downstream ALU
  a  out  4  registered operand A to the ALU
  b  out  4  registered operand B to the ALU
  op  out  3  registered function code to the ALU
  result_q  out  4  latched ALU result
  result_valid  out  1  high while result_q holds a fresh result
  led_stage  out  4  one-hot stage indicator: [0]=LOAD_A, [1]=LOAD_B, [2]=LOAD_F, [3]=SHOW

Function
REQ-004 Both buttons SHALL pass through a 2-flop synchronizer before any other use.
REQ-005 An advance pulse SHALL be exactly one clk cycle, generated on the rising edge of the conditioned btn_next; a held button SHALL yield one pulse only.
REQ-006 The clear pulse SHALL be generated from btn_clr in the same way as the advance pulse.
REQ-007 The FSM SHALL have the states LOAD_A, LOAD_B, LOAD_F, EXEC and SHOW.
REQ-008 On an advance pulse in LOAD_A, the block SHALL register sw into a and go to LOAD_B.
REQ-009 On an advance pulse in LOAD_B, the block SHALL register sw into b and go to LOAD_F.
REQ-010 On an advance pulse in LOAD_F, the block SHALL register sw[2:0] into op and go to EXEC; sw[3] is ignored.
REQ-011 EXEC SHALL last exactly one cycle, register alu_result into result_q, set result_valid=1, and go to SHOW.
REQ-012 Advance pulses arriving during EXEC SHALL be ignored.
REQ-013 Latency from the LOAD_F advance pulse to result_valid=1 SHALL be 2 clk cycles.
REQ-014 On an advance pulse in SHOW, the block SHALL clear result_valid and go to LOAD_A; a, b, op and result_q SHALL hold their values.
REQ-015 Op codes 5-7 SHALL be forwarded unchanged; the block performs no opcode validation (the ALU returns 0 for these codes).
REQ-016 A clear pulse in any state SHALL zero a, b, op and result_q, clear result_valid, and go to LOAD_A.
REQ-017 A clear pulse SHALL take priority over an advance pulse arriving in the same cycle.
REQ-018 led_stage SHALL decode the state; in EXEC it SHALL show 4'b1000.
REQ-019 All outputs SHALL be registered; a, b and op SHALL be stable whenever the FSM is in EXEC.

Reset
REQ-020 Assertion of rst_n SHALL immediately force state=LOAD_A, a=0, b=0, op=0, result_q=0, result_valid=0, led_stage=4'b0001.
REQ-021 Reset SHALL also clear the synchronizer, debounce and edge-detect flops.
REQ-022 Reset applied mid-operation, including in EXEC, SHALL abort the operation with no result capture.

Configuration
REQ-023 With macro ALU_SEQ_DEBOUNCE_EN defined, each synchronized button SHALL be accepted as a level change only after DB_CYCLES consecutive stable cycles; raw press to pulse latency is 2+DB_CYCLES+1 cycles.
REQ-024 Without ALU_SEQ_DEBOUNCE_EN, edge detection SHALL act directly on the synchronized signal; raw press to pulse latency is 3 cycles, and no debounce counter logic is present.

Structure
REQ-025 Shared package alu_pkg SHALL hold the 3-bit opcode constants (ADD=0, SUB=1, AND=2, OR=3, XOR=4) and the state enumeration typedef.
REQ-026 Synchronization, optional debounce and edge detection SHALL form one sub-module, alu_btn_cond, instantiated once per button.

Verification
REQ-027 sw=3/advance, sw=5/advance, sw=0/advance -> a=3, b=5, op=0, result_q=8 and result_valid=1 two cycles after the third pulse, led_stage=4'b1000.
REQ-028 Load a=2, b=3, op=1 -> result_q=4'hF (wrap-around); then advance in SHOW -> LOAD_A, result_valid=0, result_q stays F.
REQ-029 Load a=9, b=6, op=6 -> op=6 forwarded, result_q=0, result_valid=1.
REQ-030 In LOAD_B with clear and advance pulsing in the same cycle -> LOAD_A, a=0, b unchanged at 0.
REQ-031 ALU_SEQ_DEBOUNCE_EN defined, DB_CYCLES=4: a 3-cycle glitch -> no state change; a 10-cycle press -> exactly one advance.
REQ-032 rst_n low for 1 cycle while in EXEC -> all outputs at reset values before the next clk edge, and result_valid never rises.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU input sequencer. Holds the
//                3-bit ALU opcode constants, the sequencer state enumeration
//                and the state-to-LED decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU function codes (3 bits). Codes 5-7 are undefined and pass through.
    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_LOAD_A = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_LOAD_F = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SHOW   = 3'd4
    } state_t;

    // One-hot stage indicator. EXEC lasts a single cycle and is shown as SHOW.
    function automatic logic [3:0] stage_led(input state_t s);
        logic [3:0] v;
        v = 4'b0001;
        case (s)
            ST_LOAD_A: v = 4'b0001;
            ST_LOAD_B: v = 4'b0010;
            ST_LOAD_F: v = 4'b0100;
            ST_EXEC,
            ST_SHOW:   v = 4'b1000;
            default:   v = 4'b0001;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_btn_cond.sv
`default_nettype none
// ============================================================================
//  Module      : alu_btn_cond
//  Description : Conditions one raw asynchronous push-button into a single
//                clk-cycle pulse on its rising edge: 2-flop synchronizer,
//                optional debounce, then edge detect.
//                Optional feature macro: ALU_SEQ_DEBOUNCE_EN
//                  defined   -> level accepted after DB_CYCLES stable cycles
//                  undefined -> edge detect acts on the synchronized level
//  Ports       : clk     - system clock
//                rst_n   - asynchronous active-low reset
//                i_btn   - raw button, active-high, asynchronous
//                o_pulse - one-cycle pulse per press
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_btn_cond #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    // The debounce window must be at least one cycle.
    generate
        if (DB_CYCLES < 1) begin : g_db_cycles_invalid
            $error("alu_btn_cond: DB_CYCLES must be >= 1");
        end
    endgenerate

    logic [1:0] r_sync;
    logic       r_prev;
    logic       w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int c_CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic               r_db_level;
    logic [c_CNT_W-1:0] r_db_cnt;

    // The counter runs only while the synchronized input differs from the
    // accepted level; any return to the accepted level restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else if (r_sync[1] == r_db_level) begin
            r_db_cnt   <= '0;
        end else if (r_db_cnt == c_CNT_W'(DB_CYCLES - 1)) begin
            r_db_level <= r_sync[1];
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt   <= r_db_cnt + 1'b1;
        end
    end

    assign w_level = r_db_level;
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_pulse = w_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/alu_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_input_sequencer
//  Description : Collects operand A, operand B and a function code from the
//                switches on successive "advance" presses, lets the external
//                ALU compute for one cycle, then latches and shows the result.
//                "Clear" returns to LOAD_A and zeroes all registers.
//                Optional feature macro: ALU_SEQ_DEBOUNCE_EN (button debounce)
//  Ports       : clk, rst_n         - clock, async active-low reset
//                sw[3:0]            - operand / opcode switches
//                btn_next, btn_clr  - raw advance / clear buttons
//                alu_result[3:0]    - combinational result from the ALU
//                a, b[3:0], op[2:0] - registered ALU inputs
//                result_q[3:0]      - latched ALU result
//                result_valid       - result_q holds a fresh result
//                led_stage[3:0]     - one-hot stage indicator
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_input_sequencer
    import alu_pkg::*;
#(
    parameter int DB_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_next,
    input  logic       btn_clr,
    input  logic [3:0] alu_result,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] op,
    output logic [3:0] result_q,
    output logic       result_valid,
    output logic [3:0] led_stage
);

    logic   w_adv;
    logic   w_clr;
    state_t r_state;
    state_t w_state_next;

    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [2:0] r_op;
    logic [3:0] r_result;
    logic       r_valid;
    logic [3:0] r_led;

    alu_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_next),
        .o_pulse (w_adv)
    );

    alu_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_clr),
        .o_pulse (w_clr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear wins over advance; EXEC ignores advance and always moves on.
    always_comb begin
        w_state_next = r_state;
        if (w_clr) begin
            w_state_next = ST_LOAD_A;
        end else begin
            case (r_state)
                ST_LOAD_A: if (w_adv) w_state_next = ST_LOAD_B;
                ST_LOAD_B: if (w_adv) w_state_next = ST_LOAD_F;
                ST_LOAD_F: if (w_adv) w_state_next = ST_EXEC;
                ST_EXEC:              w_state_next = ST_SHOW;
                ST_SHOW:   if (w_adv) w_state_next = ST_LOAD_A;
                default:              w_state_next = ST_LOAD_A;
            endcase
        end
    end

    // Datapath registers. a/b/op only change in the LOAD states, so they are
    // stable throughout EXEC while the ALU computes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_op     <= 3'd0;
            r_result <= 4'd0;
            r_valid  <= 1'b0;
            r_led    <= stage_led(ST_LOAD_A);
        end else begin
            r_led <= stage_led(w_state_next);
            if (w_clr) begin
                r_a      <= 4'd0;
                r_b      <= 4'd0;
                r_op     <= 3'd0;
                r_result <= 4'd0;
                r_valid  <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD_A: if (w_adv) r_a  <= sw;
                    ST_LOAD_B: if (w_adv) r_b  <= sw;
                    ST_LOAD_F: if (w_adv) r_op <= sw[2:0];
                    ST_EXEC: begin
                        r_result <= alu_result;
                        r_valid  <= 1'b1;
                    end
                    ST_SHOW:   if (w_adv) r_valid <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign a            = r_a;
    assign b            = r_b;
    assign op           = r_op;
    assign result_q     = r_result;
    assign result_valid = r_valid;
    assign led_stage    = r_led;

endmodule
`default_nettype wire

// File: tb/tb_alu_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_input_sequencer
//  Description : Self-checking bench for alu_input_sequencer. A behavioural
//                4-bit ALU closes the loop; expected results are pushed into
//                a queue by the stimulus and popped by a monitor whenever
//                result_valid rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_input_sequencer;

    localparam int DB = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int c_HOLD = DB + 6;
    localparam int c_LAT  = 4 + DB;
`else
    localparam int c_HOLD = 4;
    localparam int c_LAT  = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = 4'd0;
    logic       btn_next = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] alu_result;
    logic [3:0] a, b, result_q, led_stage;
    logic [2:0] op;
    logic       result_valid;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    alu_input_sequencer #(.DB_CYCLES(DB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .btn_next     (btn_next),
        .btn_clr      (btn_clr),
        .alu_result   (alu_result),
        .a            (a),
        .b            (b),
        .op           (op),
        .result_q     (result_q),
        .result_valid (result_valid),
        .led_stage    (led_stage)
    );

    // Downstream ALU
    always_comb begin
        alu_result = 4'd0;
        case (op)
            3'd0: alu_result = a + b;
            3'd1: alu_result = a - b;
            3'd2: alu_result = a & b;
            3'd3: alu_result = a | b;
            3'd4: alu_result = a ^ b;
            default: alu_result = 4'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising result_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            prev_valid <= result_valid;
            if (result_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(result_q), 32'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_a", 32'(a), 32'(e.a));
                    chk("sb_b", 32'(b), 32'(e.b));
                    chk("sb_op", 32'(op), 32'(e.op));
                    chk("sb_result", 32'(result_q), 32'(e.r));
                    chk("sb_led", 32'(led_stage), 32'h8);
                end
            end
        end
    end

    task automatic press_next(input logic [3:0] v);
        @(posedge clk); #1;
        sw = v;
        btn_next = 1'b1;
        repeat (c_HOLD) @(posedge clk);
        #1 btn_next = 1'b0;
        repeat (c_HOLD) @(posedge clk);
    endtask

    task automatic press_clr();
        @(posedge clk); #1;
        btn_clr = 1'b1;
        repeat (c_HOLD) @(posedge clk);
        #1 btn_clr = 1'b0;
        repeat (c_HOLD) @(posedge clk);
    endtask

    // Final advance in LOAD_F, measuring edges from the press to result_valid.
    task automatic press_timed(input logic [3:0] v, output int lat);
        @(posedge clk); #1;
        sw = v;
        btn_next = 1'b1;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (result_valid) begin
                lat = i;
                break;
            end
        end
        repeat (c_HOLD) @(posedge clk);
        #1 btn_next = 1'b0;
        repeat (c_HOLD) @(posedge clk);
    endtask

    initial begin
        int  lat;
        bit  found;
        bit  saw_valid;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", 32'(a), 32'h0);
        chk("rst_b", 32'(b), 32'h0);
        chk("rst_op", 32'(op), 32'h0);
        chk("rst_result", 32'(result_q), 32'h0);
        chk("rst_valid", 32'(result_valid), 32'h0);
        chk("rst_led", 32'(led_stage), 32'h1);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 3 + 5 = 8, with latency measurement
        exp_q.push_back('{a: 4'd3, b: 4'd5, op: 3'd0, r: 4'd8});
        press_next(4'd3);
        chk("led_load_b", 32'(led_stage), 32'h2);
        press_next(4'd5);
        chk("led_load_f", 32'(led_stage), 32'h4);
        press_timed(4'd0, lat);
        chk("latency", 32'(lat), 32'(c_LAT));
        chk("show_led", 32'(led_stage), 32'h8);

        // 2 - 3 wraps to F; advance in SHOW keeps the result
        press_next(4'd0);
        exp_q.push_back('{a: 4'd2, b: 4'd3, op: 3'd1, r: 4'hF});
        press_next(4'd2);
        press_next(4'd3);
        press_next(4'd1);
        chk("sub_valid", 32'(result_valid), 32'h1);
        press_next(4'd7);
        chk("show_adv_led", 32'(led_stage), 32'h1);
        chk("show_adv_valid", 32'(result_valid), 32'h0);
        chk("show_adv_result", 32'(result_q), 32'hF);
        chk("show_adv_a", 32'(a), 32'h2);

        // Undefined opcode 6 forwarded; sw[3] ignored (sw=E loads op=6)
        exp_q.push_back('{a: 4'd9, b: 4'd6, op: 3'd6, r: 4'd0});
        press_next(4'd9);
        press_next(4'd6);
        press_next(4'hE);
        press_next(4'd0);

        // Held button gives a single advance
        @(posedge clk); #1;
        sw = 4'd7;
        btn_next = 1'b1;
        repeat (c_HOLD * 5) @(posedge clk);
        #1 btn_next = 1'b0;
        repeat (c_HOLD) @(posedge clk);
        chk("held_led", 32'(led_stage), 32'h2);
        chk("held_a", 32'(a), 32'h7);

        // Clear and advance together in LOAD_B: clear wins
        @(posedge clk); #1;
        sw = 4'd4;
        btn_next = 1'b1;
        btn_clr = 1'b1;
        repeat (c_HOLD) @(posedge clk);
        #1;
        btn_next = 1'b0;
        btn_clr = 1'b0;
        repeat (c_HOLD) @(posedge clk);
        chk("clr_led", 32'(led_stage), 32'h1);
        chk("clr_a", 32'(a), 32'h0);
        chk("clr_b", 32'(b), 32'h0);
        chk("clr_op", 32'(op), 32'h0);
        chk("clr_result", 32'(result_q), 32'h0);

        // Clear from SHOW zeroes the captured result
        exp_q.push_back('{a: 4'd5, b: 4'd3, op: 3'd4, r: 4'd6});
        press_next(4'd5);
        press_next(4'd3);
        press_next(4'd4);
        press_clr();
        chk("clr_show_led", 32'(led_stage), 32'h1);
        chk("clr_show_result", 32'(result_q), 32'h0);
        chk("clr_show_valid", 32'(result_valid), 32'h0);

        // Reset pulse while in EXEC aborts the capture
        press_next(4'd1);
        press_next(4'd2);
        @(posedge clk); #1;
        sw = 4'd0;
        btn_next = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (led_stage == 4'h8 && !result_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("exec_reached", 32'(found), 32'h1);
        rst_n = 1'b0;
        btn_next = 1'b0;
        #1;
        chk("exec_rst_a", 32'(a), 32'h0);
        chk("exec_rst_b", 32'(b), 32'h0);
        chk("exec_rst_led", 32'(led_stage), 32'h1);
        chk("exec_rst_valid", 32'(result_valid), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result_valid) saw_valid = 1'b1;
        end
        chk("exec_rst_no_valid", 32'(saw_valid), 32'h0);
        chk("exec_rst_state", 32'(led_stage), 32'h1);

`ifdef ALU_SEQ_DEBOUNCE_EN
        // 3-cycle glitch is rejected, 10-cycle press gives one advance
        @(posedge clk); #1;
        sw = 4'd9;
        btn_next = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn_next = 1'b0;
        repeat (20) @(posedge clk);
        chk("glitch_led", 32'(led_stage), 32'h1);
        chk("glitch_a", 32'(a), 32'h0);
        @(posedge clk); #1;
        btn_next = 1'b1;
        repeat (10) @(posedge clk);
        #1 btn_next = 1'b0;
        repeat (20) @(posedge clk);
        chk("db_press_led", 32'(led_stage), 32'h2);
        chk("db_press_a", 32'(a), 32'h9);
`endif

        repeat (5) @(posedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
